// File: rtl/dim_reduce_streamer.sv
// dim_reduce_streamer: walks a row-major [S0,S1,S2] tensor in word-addressed
// memory with the selected reduction dimension innermost. It streams one
// element per valid/ready handshake, tagged with its index along the
// reduction dimension and a row-last marker.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, reduce_dim, size0-2 transfer request and config (sampled on accept)
//   base_addr                  word address of element [0,0,0]
//   busy, done                 status; done pulses for one cycle at completion
//   mem_rd_en/addr/data        read port, data returned one cycle after enable
//   valid_out, ready_in        output handshake
//   output_data, elem_idx      element value and position along reduction dim
//   last_out                   final element of the current reduction row
module dim_reduce_streamer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DIM_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        reduce_dim,
  input  logic [DIM_W-1:0]  size0,
  input  logic [DIM_W-1:0]  size1,
  input  logic [DIM_W-1:0]  size2,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] output_data,
  output logic [DIM_W-1:0]  elem_idx,
  output logic              last_out
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PROD_W = 2 * DIM_W;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  sz0_q, sz0_d, sz1_q, sz1_d, sz2_q, sz2_d;
  logic [1:0]        rdim_q, rdim_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] st_a_q, st_a_d, st_b_q, st_b_d, st_k_q, st_k_d;
  logic [DIM_W-1:0]  a_q, a_d, b_q, b_d, k_q, k_d;
  logic [ADDR_W-1:0] row_q, row_d, plane_q, plane_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic [DIM_W-1:0]  rd_k_q, rd_k_d, infl_k_q, infl_k_d;
  logic              rd_last_q, rd_last_d, infl_last_q, infl_last_d;
  logic              infl_q, infl_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0]  resv_q, resv_d, cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DIM_W-1:0]  fifo_k_q    [FIFO_DEPTH];
  logic              fifo_last_q [FIFO_DEPTH];

  logic [ADDR_W-1:0] stride0_c, stride1_c, st_a_c, st_b_c, st_k_c;
  logic [DIM_W-1:0]  sz_a_c, sz_b_c, sz_k_c, last_a_c, last_b_c, last_k_c;
  logic              push_c, pop_c;

  assign push_c = infl_q;
  assign pop_c  = (cnt_q != '0) && ready_in;

  // Loop geometry: a = outer, b = middle, k = reduction dim (innermost).
  always_comb begin : sel_geom
    stride0_c = ADDR_W'(PROD_W'(sz1_q) * PROD_W'(sz2_q));
    stride1_c = ADDR_W'(sz2_q);
    case (rdim_q)
      2'd0: begin
        sz_a_c = sz1_q; sz_b_c = sz2_q; sz_k_c = sz0_q;
        st_a_c = stride1_c; st_b_c = ADDR_W'(1); st_k_c = stride0_c;
      end
      2'd1: begin
        sz_a_c = sz0_q; sz_b_c = sz2_q; sz_k_c = sz1_q;
        st_a_c = stride0_c; st_b_c = ADDR_W'(1); st_k_c = stride1_c;
      end
      default: begin
        sz_a_c = sz0_q; sz_b_c = sz1_q; sz_k_c = sz2_q;
        st_a_c = stride0_c; st_b_c = stride1_c; st_k_c = ADDR_W'(1);
      end
    endcase
    last_a_c = sz_a_c - DIM_W'(1);
    last_b_c = sz_b_c - DIM_W'(1);
    last_k_c = sz_k_c - DIM_W'(1);
  end

  // Next-state and read scheduling. mem_rd_en_d decides the read visible next
  // cycle; resv counts FIFO entries plus reads not yet written, so checking it
  // one cycle early equals checking fifo_count + inflight in the read cycle.
  always_comb begin : next_state
    state_d       = state_q;
    sz0_d         = sz0_q;
    sz1_d         = sz1_q;
    sz2_d         = sz2_q;
    rdim_d        = rdim_q;
    base_d        = base_q;
    st_a_d        = st_a_q;
    st_b_d        = st_b_q;
    st_k_d        = st_k_q;
    a_d           = a_q;
    b_d           = b_q;
    k_d           = k_q;
    row_d         = row_q;
    plane_d       = plane_q;
    mem_rd_en_d   = 1'b0;
    mem_rd_addr_d = mem_rd_addr_q;
    rd_k_d        = rd_k_q;
    rd_last_d     = rd_last_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sz0_d   = size0;
          sz1_d   = size1;
          sz2_d   = size2;
          rdim_d  = reduce_dim;
          base_d  = base_addr;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        st_a_d = st_a_c;
        st_b_d = st_b_c;
        st_k_d = st_k_c;
        if (sz0_q == '0 || sz1_q == '0 || sz2_q == '0) begin
          state_d = S_DONE;
        end else begin
          // First element is always base; FIFO is empty so no credit check.
          a_d           = '0;
          b_d           = '0;
          k_d           = '0;
          row_d         = base_q;
          plane_d       = base_q;
          mem_rd_en_d   = 1'b1;
          mem_rd_addr_d = base_q;
          rd_k_d        = '0;
          rd_last_d     = (last_k_c == '0);
          state_d = (last_a_c == '0 && last_b_c == '0 && last_k_c == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (resv_q < CNT_W'(FIFO_DEPTH) || pop_c) begin
          if (k_q != last_k_c) begin
            k_d           = k_q + DIM_W'(1);
            mem_rd_addr_d = mem_rd_addr_q + st_k_q;
          end else if (b_q != last_b_c) begin
            k_d           = '0;
            b_d           = b_q + DIM_W'(1);
            row_d         = row_q + st_b_q;
            mem_rd_addr_d = row_q + st_b_q;
          end else begin
            k_d           = '0;
            b_d           = '0;
            a_d           = a_q + DIM_W'(1);
            plane_d       = plane_q + st_a_q;
            row_d         = plane_q + st_a_q;
            mem_rd_addr_d = plane_q + st_a_q;
          end
          mem_rd_en_d = 1'b1;
          rd_k_d      = k_d;
          rd_last_d   = (k_d == last_k_c);
          if (a_d == last_a_c && b_d == last_b_c && k_d == last_k_c) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (resv_q == '0 || (resv_q == CNT_W'(1) && pop_c)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    resv_d      = resv_q + CNT_W'(mem_rd_en_d) - CNT_W'(pop_c);
    cnt_d       = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    wr_ptr_d    = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    infl_d      = mem_rd_en_q;
    infl_k_d    = rd_k_q;
    infl_last_d = rd_last_q;
    busy_d      = (state_d == S_SETUP) || (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d      = (state_d == S_DONE);
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sz0_q         <= '0;
      sz1_q         <= '0;
      sz2_q         <= '0;
      rdim_q        <= '0;
      base_q        <= '0;
      st_a_q        <= '0;
      st_b_q        <= '0;
      st_k_q        <= '0;
      a_q           <= '0;
      b_q           <= '0;
      k_q           <= '0;
      row_q         <= '0;
      plane_q       <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      rd_k_q        <= '0;
      rd_last_q     <= 1'b0;
      infl_q        <= 1'b0;
      infl_k_q      <= '0;
      infl_last_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      resv_q        <= '0;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      sz0_q         <= sz0_d;
      sz1_q         <= sz1_d;
      sz2_q         <= sz2_d;
      rdim_q        <= rdim_d;
      base_q        <= base_d;
      st_a_q        <= st_a_d;
      st_b_q        <= st_b_d;
      st_k_q        <= st_k_d;
      a_q           <= a_d;
      b_q           <= b_d;
      k_q           <= k_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      rd_k_q        <= rd_k_d;
      rd_last_q     <= rd_last_d;
      infl_q        <= infl_d;
      infl_k_q      <= infl_k_d;
      infl_last_q   <= infl_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      resv_q        <= resv_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Output FIFO storage; the entry is written the cycle the read data returns.
  always_ff @(posedge clk or negedge rst_n) begin : fifo_store
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_k_q[i]    <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else if (push_c) begin
      fifo_data_q[wr_ptr_q] <= mem_rd_data;
      fifo_k_q[wr_ptr_q]    <= infl_k_q;
      fifo_last_q[wr_ptr_q] <= infl_last_q;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign valid_out   = (cnt_q != '0);
  assign output_data = fifo_data_q[rd_ptr_q];
  assign elem_idx    = fifo_k_q[rd_ptr_q];
  assign last_out    = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_dim_reduce_streamer.sv
// Scoreboard bench for dim_reduce_streamer: golden addresses and elements are
// queued when a transfer is started and popped as the DUT issues reads and
// completes output handshakes.
module tb_dim_reduce_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  reduce_dim = 2'd0;
  logic [7:0]  size0 = 8'd0, size1 = 8'd0, size2 = 8'd0;
  logic [15:0] base_addr = 16'd0;
  logic        busy, done, mem_rd_en, valid_out, last_out;
  logic        ready_in = 1'b0;
  logic [15:0] mem_rd_addr;
  logic [31:0] mem_rd_data = 32'd0;
  logic [31:0] output_data;
  logic [7:0]  elem_idx;

  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  logic        hold = 1'b0;
  logic [40:0] held = '0;
  logic [15:0] exp_addr_q[$];
  logic [40:0] exp_q[$];

  dim_reduce_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reduce_dim(reduce_dim),
    .size0(size0), .size1(size1), .size2(size2), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .valid_out(valid_out), .ready_in(ready_in),
    .output_data(output_data), .elem_idx(elem_idx), .last_out(last_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mval(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // Memory model: one-cycle read latency, garbage when not read.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mval(mem_rd_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ready_in driver: 0 = held high, 1 = random 50%, 2 = held low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) ready_in = 1'b1;
      else if (rdy_mode == 1) ready_in = 1'($urandom_range(0, 1));
      else ready_in = 1'b0;
    end
  end

  // Monitor: reads, handshakes, hold stability, credit bound.
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_cnt = rd_cnt;
      hold = 1'b0;
    end else begin
      if (mem_rd_en) begin
        rd_cnt++;
        if (exp_addr_q.size() == 0) chk("rd_extra", 64'(exp_addr_q.size()), 64'd1);
        else chk("rd_addr", 64'(mem_rd_addr), 64'(exp_addr_q.pop_front()));
      end
      if (rd_cnt - hs_cnt > 4) chk("outstanding", 64'(rd_cnt - hs_cnt), 64'd4);
      if (hold) begin
        chk("hold_valid", 64'(valid_out), 64'd1);
        chk("hold_payload", 64'({output_data, elem_idx, last_out}), 64'(held));
      end
      if (valid_out && ready_in) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("hs_extra", 64'(exp_q.size()), 64'd1);
        else chk("elem", 64'({output_data, elem_idx, last_out}), 64'(exp_q.pop_front()));
      end
      hold = valid_out && !ready_in;
      held = {output_data, elem_idx, last_out};
      if (done) done_cnt++;
    end
  end

  task automatic push_golden(input logic [7:0] s0, s1, s2, input logic [1:0] rd,
                             input logic [15:0] base);
    int sz[3];
    int idx[3];
    int red, oa, ob, full;
    logic [15:0] a;
    sz[0] = int'(s0); sz[1] = int'(s1); sz[2] = int'(s2);
    red = (rd == 2'd3) ? 2 : int'(rd);
    oa = (red == 0) ? 1 : 0;
    ob = (red == 2) ? 1 : 2;
    for (int i = 0; i < sz[oa]; i++)
      for (int j = 0; j < sz[ob]; j++)
        for (int k = 0; k < sz[red]; k++) begin
          idx[oa] = i; idx[ob] = j; idx[red] = k;
          full = int'(base) + idx[0] * sz[1] * sz[2] + idx[1] * sz[2] + idx[2];
          a = 16'(full);
          exp_addr_q.push_back(a);
          exp_q.push_back({mval(a), 8'(k), (k == sz[red] - 1)});
        end
  endtask

  // Pulse start for one cycle (cycle 0 = t0), then scramble the config pins.
  task automatic start_xfer(input logic [7:0] s0, s1, s2, input logic [1:0] rd,
                            input logic [15:0] base, output int t0);
    push_golden(s0, s1, s2, rd, base);
    @(posedge clk);
    #1;
    size0 = s0; size1 = s1; size2 = s2; reduce_dim = rd; base_addr = base;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_cycle1", 64'(busy), 64'd1);
    size0 = 8'($urandom); size1 = 8'($urandom); size2 = 8'($urandom);
    reduce_dim = 2'($urandom); base_addr = 16'($urandom);
  endtask

  task automatic wait_done(input int t0, output int dcyc);
    logic seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dcyc = cyc - t0;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic finish_checks(input int rb, hb, db, total);
    repeat (4) @(negedge clk);
    chk("n_reads", 64'(rd_cnt - rb), 64'(total));
    chk("n_handshakes", 64'(hs_cnt - hb), 64'(total));
    chk("n_done", 64'(done_cnt - db), 64'd1);
    chk("queue_left", 64'(exp_q.size() + exp_addr_q.size()), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  // Full transfer; exp_done < 0 skips the done-latency check.
  task automatic run_xfer(input logic [7:0] s0, s1, s2, input logic [1:0] rd,
                          input logic [15:0] base, input int exp_done, input bit chk_lat);
    int rb, hb, db, t0, dc, lat;
    rb = rd_cnt; hb = hs_cnt; db = done_cnt; lat = -1;
    start_xfer(s0, s1, s2, rd, base, t0);
    if (chk_lat) begin
      for (int i = 0; i < 10 && lat < 0; i++) begin
        @(negedge clk);
        if (valid_out) lat = cyc - t0;
      end
      chk("first_valid_lat", 64'(lat), 64'd4);
    end
    wait_done(t0, dc);
    if (exp_done >= 0) chk("done_lat", 64'(dc), 64'(exp_done));
    finish_checks(rb, hb, db, int'(s0) * int'(s1) * int'(s2));
  endtask

  initial begin
    int rb, hb, db, t0, dc;
    #1 rst_n = 1'b0;
    #3;
    chk("reset_outs", 64'({busy, done, mem_rd_en, mem_rd_addr, valid_out,
                           output_data, elem_idx, last_out}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Main function across reduction dims with ready held high.
    run_xfer(8'd2, 8'd3, 8'd4, 2'd1, 16'h0100, 28, 1'b1);
    run_xfer(8'd2, 8'd3, 8'd4, 2'd0, 16'h0100, 28, 1'b1);
    run_xfer(8'd2, 8'd3, 8'd4, 2'd2, 16'h0100, 28, 1'b0);
    run_xfer(8'd3, 8'd1, 8'd5, 2'd3, 16'hFFF8, 19, 1'b0);
    run_xfer(8'd4, 8'd1, 8'd3, 2'd1, 16'h0020, 16, 1'b0);

    // Backpressure: ready low for 10 cycles mid-stream.
    rb = rd_cnt; hb = hs_cnt; db = done_cnt;
    start_xfer(8'd2, 8'd3, 8'd4, 2'd2, 16'h0100, t0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rdy_mode = 2;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("stall_outstanding", 64'(rd_cnt - hs_cnt), 64'd4);
    chk("stall_rd_en", 64'(mem_rd_en), 64'd0);
    chk("stall_valid", 64'(valid_out), 64'd1);
    rdy_mode = 0;
    wait_done(t0, dc);
    finish_checks(rb, hb, db, 24);

    // Random ready.
    rdy_mode = 1;
    run_xfer(8'd2, 8'd3, 8'd4, 2'd1, 16'h0100, -1, 1'b0);
    run_xfer(8'd2, 8'd3, 8'd4, 2'd0, 16'h0300, -1, 1'b0);
    rdy_mode = 0;

    // Zero size: no reads, done two cycles after start.
    rb = rd_cnt; hb = hs_cnt; db = done_cnt;
    start_xfer(8'd2, 8'd0, 8'd4, 2'd1, 16'h0100, t0);
    wait_done(t0, dc);
    chk("zero_done_lat", 64'(dc), 64'd2);
    finish_checks(rb, hb, db, 0);

    // start while busy is ignored.
    rb = rd_cnt; hb = hs_cnt; db = done_cnt;
    start_xfer(8'd2, 8'd3, 8'd4, 2'd3, 16'h0200, t0);
    repeat (4) @(posedge clk);
    #1;
    size0 = 8'd1; size1 = 8'd1; size2 = 8'd1; reduce_dim = 2'd0; base_addr = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(t0, dc);
    chk("busy_start_done_lat", 64'(dc), 64'd28);
    finish_checks(rb, hb, db, 24);

    // Async reset in cycle 8 of a transfer, then a clean transfer.
    start_xfer(8'd2, 8'd3, 8'd4, 2'd1, 16'h0040, t0);
    repeat (7) @(posedge clk);
    #2;
    chk("pre_reset_valid", 64'(valid_out), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_outs", 64'({busy, done, mem_rd_en, mem_rd_addr, valid_out,
                               output_data, elem_idx, last_out}), 64'd0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_xfer(8'd2, 8'd3, 8'd4, 2'd1, 16'h0040, 28, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
